// File: rtl/hazard_ctrl.sv
// Central hazard controller: load-use bubbles, memory-wait freeze, branch flush (deferred across memory stalls),
// EX-stage forwarding selects, plus a saturating stall counter and a sticky memory-timeout flag.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memtoreg,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic             hold_front,
  output logic             ifid_flush,
  output logic             bubble,
  output logic             hold_back,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_error
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mem_error_q, mem_error_d;

  logic memstall, lu, flushing;
  logic hf_run, flush_run, bub_run, hb_run;

  assign memstall = mem_access & ~mem_ready;

  assign lu = ex_memtoreg && (ex_rt != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

  // Flushes only fire in RUN: a branch seen during a memory wait is parked in
  // flush_pend and replayed on the first RUN cycle after the wait releases.
  assign flushing = (state_q == RUN) && (ex_branch_taken || flush_pend_q);

  always_comb begin
    hf_run    = 1'b0;
    flush_run = 1'b0;
    bub_run   = 1'b0;
    hb_run    = 1'b0;
    if (memstall) begin
      hf_run = 1'b1;
      hb_run = 1'b1;
    end else if (flushing) begin
      flush_run = 1'b1;
      bub_run   = 1'b1;
    end else if (lu) begin
      hf_run  = 1'b1;
      bub_run = 1'b1;
    end
  end

  // Outputs are forced to a safe freeze while reset is asserted.
  assign hold_front = ~rst_n | hf_run;
  assign bubble     = ~rst_n | bub_run;
  assign ifid_flush = rst_n & flush_run;
  assign hold_back  = rst_n & hb_run;

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    wcnt_d       = wcnt_q;
    mem_error_d  = mem_error_q;
    stall_cnt_d  = stall_cnt_q;

    case (state_q)
      RUN: begin
        wcnt_d = 16'd0;
        if (memstall) begin
          state_d = MEM_WAIT;
          if (ex_branch_taken) flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (ex_branch_taken) flush_pend_d = 1'b1;
        if (mem_ready) begin
          state_d = RUN;
        end else if (memstall && (wcnt_q != TIMEOUT)) begin
          wcnt_d = wcnt_q + 16'd1;
        end
        if (wcnt_d == TIMEOUT) mem_error_d = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (hf_run && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      wcnt_q       <= 16'd0;
      stall_cnt_q  <= '0;
      mem_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      wcnt_q       <= wcnt_d;
      stall_cnt_q  <= stall_cnt_d;
      mem_error_q  <= mem_error_d;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == src)) return 2'b10;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == src)) return 2'b01;
    else return 2'b00;
  endfunction

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst_n) begin
      fwd_a = fwd_sel(ex_rs);
      fwd_b = fwd_sel(ex_rt);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign mem_error = mem_error_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=8, CNT_W=4) with hand-computed expectations.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, ex_memtoreg, ex_branch_taken;
  logic       mem_regwrite, mem_access, mem_ready, wb_regwrite;
  logic       hold_front, ifid_flush, bubble, hold_back, mem_error;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memtoreg(ex_memtoreg), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_access(mem_access), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .hold_front(hold_front), .ifid_flush(ifid_flush), .bubble(bubble), .hold_back(hold_back),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .mem_error(mem_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_memtoreg = 0; ex_branch_taken = 0;
    mem_rd = 0; mem_regwrite = 0; mem_access = 0; mem_ready = 0;
    wb_rd = 0; wb_regwrite = 0;
  endtask

  // Move to 1 ns after the next rising edge; inputs are driven there and
  // outputs are sampled 1 ns later, well clear of both edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ctl(input string tag, input logic hf, input logic hb, input logic fl, input logic bb);
    chk({tag, ".hold_front"}, 32'(hold_front), 32'(hf));
    chk({tag, ".hold_back"},  32'(hold_back),  32'(hb));
    chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
    chk({tag, ".bubble"},     32'(bubble),     32'(bb));
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_access = i[0]; mem_ready = 1'b0; ex_branch_taken = 1'b1;
      ex_rs = 5'd3; ex_rt = 5'd3; mem_rd = 5'd3; mem_regwrite = 1'b1;
      settle();
      if (i == 1) begin
        ctl("rst", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst.fwd_a", 32'(fwd_a), 32'd0);
        chk("rst.fwd_b", 32'(fwd_b), 32'd0);
      end
      tick();
    end
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    rst_n = 1'b1;

    // Reset with toggling inputs, then one idle cycle
    do_reset();
    settle();
    ctl("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("post_rst.mem_error", 32'(mem_error), 32'd0);

    // Load-use for one cycle
    tick();
    ex_memtoreg = 1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
    settle();
    ctl("lu", 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    ex_memtoreg = 0;
    settle();
    ctl("lu_next", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu.stall_cnt", 32'(stall_cnt), 32'd1);
    // rt via id_rt path, but ex_rt = 0 never hazards
    tick();
    ex_memtoreg = 1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1;
    settle();
    ctl("lu_r0", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    settle();
    chk("lu_r0.stall_cnt", 32'(stall_cnt), 32'd1);

    // Forwarding priority and r0 exclusion
    ex_rs = 5'd3; ex_rt = 5'd7; mem_rd = 5'd3; mem_regwrite = 1; wb_rd = 5'd3; wb_regwrite = 1;
    settle();
    chk("fwd.a_mem", 32'(fwd_a), 32'd2);
    chk("fwd.b_none", 32'(fwd_b), 32'd0);
    mem_regwrite = 0;
    settle();
    chk("fwd.a_wb", 32'(fwd_a), 32'd1);
    wb_rd = 5'd7;
    settle();
    chk("fwd.b_wb", 32'(fwd_b), 32'd1);
    chk("fwd.a_none", 32'(fwd_a), 32'd0);
    ex_rs = 5'd0; wb_rd = 5'd0; mem_rd = 5'd0; mem_regwrite = 1;
    settle();
    chk("fwd.a_r0", 32'(fwd_a), 32'd0);
    idle();

    // Memory wait with deferred branch
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      mem_access = 1; mem_ready = 0; ex_branch_taken = (c == 1);
      settle();
      ctl($sformatf("mw%0d", c), 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    ex_branch_taken = 0; mem_ready = 1;
    settle();
    ctl("mw_release", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mw.stall_cnt", 32'(stall_cnt), 32'd4);
    tick();
    idle();
    settle();
    ctl("mw_flush", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    settle();
    ctl("mw_after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mw.stall_cnt_end", 32'(stall_cnt), 32'd4);

    // Branch wins over a concurrent load-use
    tick();
    ex_branch_taken = 1; ex_memtoreg = 1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1;
    settle();
    ctl("br_lu", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    idle();

    // Reset in the middle of a wait drops the pending flush
    mem_access = 1; ex_branch_taken = 1;
    tick();
    ex_branch_taken = 0;
    tick();
    do_reset();
    settle();
    ctl("rst_mid_wait", 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout: memory never ready; counter saturates at 15
    tick();
    for (int c = 1; c <= 18; c++) begin
      mem_access = 1; mem_ready = 0;
      settle();
      if (c == 9)  chk("to.err_c9", 32'(mem_error), 32'd0);
      if (c == 10) chk("to.err_c10", 32'(mem_error), 32'd1);
      if (c == 13) chk("to.stall_cnt_12", 32'(stall_cnt), 32'd12);
      tick();
    end
    mem_ready = 1;
    tick();
    idle();
    settle();
    chk("to.err_sticky", 32'(mem_error), 32'd1);
    chk("to.stall_sat", 32'(stall_cnt), 32'd15);
    ctl("to.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    settle();
    chk("to.err_cleared", 32'(mem_error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
